stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
// Consumer end of the stopwatch clock-divider interface. Samples the divider's
// mid_clk (display scan rate) and slow_clk (count rate) levels on clk, turns
// their rising edges into single-cycle enables, runs an MM:SS BCD stopwatch
// under start/stop and clear control, and drives a 4-digit multiplexed 7-seg display.
// PARAMETERS
// SLOW_PER_SEC  1  slow_clk rising edges per +1 s increment (>=1)
// PS_W          8  width of prescale counter; must hold SLOW_PER_SEC-1
// PORTS
// clk        in   1  system clock, all logic on posedge
// rst_n      in   1  async active-low reset
// mid_clk    in   1  divider scan-rate level, synchronous to clk
// slow_clk   in   1  divider count-rate level, synchronous to clk
// start_stop in   1  debounced level; rising edge toggles run/pause
// clear      in   1  debounced level; rising edge zeroes the stopwatch
// running    out  1  1 while in RUN state
// overflow   out  1  sticky: set on 59:59->00:00 rollover, cleared by clear
// an         out  4  digit anodes, active-low, one-hot-low (an[0]=sec ones)
// seg        out  7  segments, active-low, seg[0]=a .. seg[6]=g
// dp         out  1  decimal point, active-low; lit only while an[2] is low
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, all BCD digits 0, prescale 0, edge
//   history regs 0, overflow 0, running 0, scan index 0, an=4'b1110,
//   seg=7'b1000000 ('0'), dp=1. Reset release mid-operation needs no handshake.
// - Edge detect: per input, prev<=in each cycle; rise=in & ~prev. One-cycle
//   pulse, one clk after the level change is first sampled. A level already 1
//   out of reset yields a rise on the first cycle (prev reset to 0).
// - FSM: IDLE (zero, stopped), RUN, PAUSED.
//   IDLE --ss_rise--> RUN; RUN --ss_rise--> PAUSED; PAUSED --ss_rise--> RUN;
//   any --clr_rise--> IDLE (digits, prescale, overflow zeroed same edge).
// - Priority same cycle: clr_rise beats ss_rise and slow rise.
// - Counting: only when state (pre-edge value) is RUN and slow rise. prescale
//   increments; when prescale==SLOW_PER_SEC-1 it wraps to 0 and time +1 s.
//   So a slow rise coincident with ss_rise in RUN is counted; in PAUSED not.
// - PAUSED retains digits and prescale; resume continues from partial count.
// - BCD: s1 0-9, s10 0-5, m1 0-9, m10 0-5; carry ripples in one cycle.
//   59:59 +1s -> 00:00, overflow<=1, keep running.
// - Scan: each mid rise advances idx 0->1->2->3->0. an, seg, dp registered,
//   updated on the same edge idx advances (seg shows new digit's current value);
//   seg also refreshes every cycle from live digit so counts show without
//   waiting for a scan step. Idx advances in all states.
// - Encoding (gfedcba, active-low): 0=1000000 1=1111001 2=0100100 3=0110000
//   4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
// - running = (state==RUN), registered with state.
// TESTING
// 1 Reset: drive rst_n=0 mid-RUN at 12:34 -> immediately an=1110, seg=1000000,
//   running=0, overflow=0; after release time 00:00, state IDLE.
// 2 Count: SLOW_PER_SEC=1, start, 75 slow rises -> 01:15, running=1; pause,
//   10 more slow rises -> still 01:15; resume, 1 rise -> 01:16.
// 3 Prescale: SLOW_PER_SEC=4, start, 3 rises, pause, resume, 1 rise -> 00:01;
//   hold slow_clk high 50 cycles -> counts once only.
// 4 Rollover: preload by 3599 rises -> 59:59; 1 more -> 00:00, overflow=1,
//   running=1; clear -> overflow=0, IDLE.
// 5 Simultaneous: clear+start_stop+slow rise same cycle in RUN -> IDLE, 00:00;
//   start_stop+slow rise in RUN -> PAUSED and count incremented.
// 6 Scan: time 04:27, 4 mid rises -> an 1101/1011/0111/1110, seg 0100100
//   ('2'), 0011001 ('4'), 1000000 ('0'), 1111000 ('7'); dp=0 only at an=1011.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch driven by divider scan/count levels, with a
// 4-digit multiplexed active-low 7-segment display.
module stopwatch_core #(
  parameter int SLOW_PER_SEC = 1,
  parameter int PS_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mid_clk,
  input  logic       slow_clk,
  input  logic       start_stop,
  input  logic       clear,
  output logic       running,
  output logic       overflow,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t state_q, state_d;
  logic [3:0] s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d, an_q, an_d, dig;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [1:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic mid_prev_q, slow_prev_q, ss_prev_q, clr_prev_q;
  logic mid_rise, slow_rise, ss_rise, clr_rise;
  logic ovf_q, ovf_d, run_q, run_d, dp_q, dp_d, tick;
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      default: enc = 7'b0010000;
    endcase
  endfunction
  assign mid_rise  = mid_clk & ~mid_prev_q;
  assign slow_rise = slow_clk & ~slow_prev_q;
  assign ss_rise   = start_stop & ~ss_prev_q;
  assign clr_rise  = clear & ~clr_prev_q;
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s10_d   = s10_q;
    m1_d    = m1_q;
    m10_d   = m10_q;
    ps_d    = ps_q;
    ovf_d   = ovf_q;
    tick    = 1'b0;
    if (clr_rise) begin
      state_d = IDLE;
      s1_d    = '0;
      s10_d   = '0;
      m1_d    = '0;
      m10_d   = '0;
      ps_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      // counting uses the pre-edge state, so a tick coincident with a pause still lands
      if (state_q == RUN && slow_rise) begin
        tick = ps_q == PS_W'(SLOW_PER_SEC - 1);
        ps_d = tick ? '0 : ps_q + 1'b1;
      end
      if (tick) begin
        s1_d = s1_q == 4'd9 ? 4'd0 : s1_q + 4'd1;
        if (s1_q == 4'd9) begin
          s10_d = s10_q == 4'd5 ? 4'd0 : s10_q + 4'd1;
          if (s10_q == 4'd5) begin
            m1_d = m1_q == 4'd9 ? 4'd0 : m1_q + 4'd1;
            if (m1_q == 4'd9) begin
              m10_d = m10_q == 4'd5 ? 4'd0 : m10_q + 4'd1;
              ovf_d = ovf_q | (m10_q == 4'd5);
            end
          end
        end
      end
      if (ss_rise) state_d = state_q == RUN ? PAUSED : RUN;
    end
    idx_d = idx_q + {1'b0, mid_rise};
    dig   = idx_d == 2'd0 ? s1_d : idx_d == 2'd1 ? s10_d : idx_d == 2'd2 ? m1_d : m10_d;
    an_d  = ~(4'b0001 << idx_d);
    seg_d = enc(dig);
    dp_d  = idx_d != 2'd2;
    run_d = state_d == RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s1_q        <= '0;
      s10_q       <= '0;
      m1_q        <= '0;
      m10_q       <= '0;
      ps_q        <= '0;
      ovf_q       <= 1'b0;
      run_q       <= 1'b0;
      idx_q       <= '0;
      an_q        <= 4'b1110;
      seg_q       <= 7'b1000000;
      dp_q        <= 1'b1;
      mid_prev_q  <= 1'b0;
      slow_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      clr_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s10_q       <= s10_d;
      m1_q        <= m1_d;
      m10_q       <= m10_d;
      ps_q        <= ps_d;
      ovf_q       <= ovf_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      mid_prev_q  <= mid_clk;
      slow_prev_q <= slow_clk;
      ss_prev_q   <= start_stop;
      clr_prev_q  <= clear;
    end
  end
  assign running  = run_q;
  assign overflow = ovf_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: two instances (1 and 4 slow ticks per second) on shared stimulus,
// checked against a seconds-count model of the stopwatch.
module tb_stopwatch_core;
  logic clk, rst_n, mid_clk, slow_clk, start_stop, clear;
  logic [1:0] run, ovf, dp;
  logic [1:0][3:0] an;
  logic [1:0][6:0] seg;
  int n_chk, n_fail;
  int m_st[2], m_secs[2], m_ps[2], m_idx;
  bit m_ovf[2];
  int per[2] = '{1, 4};
  bit p_c, p_s, p_sl, p_m;
  logic [6:0] codes[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  stopwatch_core #(.SLOW_PER_SEC(1), .PS_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .mid_clk(mid_clk), .slow_clk(slow_clk),
    .start_stop(start_stop), .clear(clear), .running(run[0]), .overflow(ovf[0]),
    .an(an[0]), .seg(seg[0]), .dp(dp[0]));
  stopwatch_core #(.SLOW_PER_SEC(4), .PS_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .mid_clk(mid_clk), .slow_clk(slow_clk),
    .start_stop(start_stop), .clear(clear), .running(run[1]), .overflow(ovf[1]),
    .an(an[1]), .seg(seg[1]), .dp(dp[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dec(input logic [6:0] s);
    dec = -1;
    for (int i = 0; i < 10; i++) if (codes[i] === s) dec = i;
  endfunction

  function automatic int digit_of(input int secs, input int pos);
    digit_of = pos == 0 ? secs % 10 : pos == 1 ? (secs / 10) % 6 :
               pos == 2 ? (secs / 60) % 10 : secs / 600;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_secs[k] = 0; m_ps[k] = 0; m_ovf[k] = 0;
    end
    m_idx = 0; p_c = 0; p_s = 0; p_sl = 0; p_m = 0;
  endtask

  task automatic step(input bit c, input bit s, input bit sl, input bit m);
    bit cr, sr, slr;
    cr = c & ~p_c; sr = s & ~p_s; slr = sl & ~p_sl;
    for (int k = 0; k < 2; k++) begin
      if (cr) begin
        m_st[k] = 0; m_secs[k] = 0; m_ps[k] = 0; m_ovf[k] = 0;
      end else begin
        if (m_st[k] == 1 && slr) begin
          m_ps[k]++;
          if (m_ps[k] == per[k]) begin
            m_ps[k] = 0;
            m_secs[k] = (m_secs[k] + 1) % 3600;
            if (m_secs[k] == 0) m_ovf[k] = 1;
          end
        end
        if (sr) m_st[k] = m_st[k] == 1 ? 2 : 1;
      end
    end
    if (m & ~p_m) m_idx = (m_idx + 1) % 4;
    clear = c; start_stop = s; slow_clk = sl; mid_clk = m;
    @(posedge clk); #1;
    p_c = c; p_s = s; p_sl = sl; p_m = m;
  endtask

  task automatic idle_cyc(); step(0, 0, 0, 0); endtask
  task automatic pulse_slow(input int n);
    repeat (n) begin step(0, 0, 1, 0); idle_cyc(); end
  endtask
  task automatic pulse_ss(); step(0, 1, 0, 0); idle_cyc(); endtask
  task automatic pulse_clr(); step(1, 0, 0, 0); idle_cyc(); endtask
  task automatic pulse_mid(); step(0, 0, 0, 1); idle_cyc(); endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    clear = 0; start_stop = 0; slow_clk = 0; mid_clk = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Scans all four digits of instance k and reconstructs the displayed time.
  task automatic read_time(input int k, output int secs, output bit ok);
    int d[4];
    bit [3:0] seen;
    ok = 1; seen = 0; d = '{0, 0, 0, 0};
    repeat (4) begin
      int p;
      pulse_mid();
      p = -1;
      for (int i = 0; i < 4; i++) if (an[k] === ~(4'b0001 << i)) p = i;
      if (p < 0 || dec(seg[k]) < 0) ok = 0;
      else begin
        d[p] = dec(seg[k]);
        seen[p] = 1;
        if (dp[k] !== (p != 2)) ok = 0;
      end
    end
    if (seen != 4'hF) ok = 0;
    secs = d[3] * 600 + d[2] * 60 + d[1] * 10 + d[0];
  endtask

  task automatic check_time(input int k, input string name);
    int t;
    bit ok;
    read_time(k, t, ok);
    n_chk++;
    if (!ok || t !== m_secs[k]) begin
      n_fail++;
      $display("FAIL %s: dut%0d shows %0d s (scan ok=%0b), expected %0d s", name, k, t, ok, m_secs[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; clear = 0; start_stop = 0; slow_clk = 0; mid_clk = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (an !== {4'b1110, 4'b1110} || seg !== {7'b1000000, 7'b1000000} || dp !== 2'b11 ||
        run !== 2'b00 || ovf !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_initial: an=%h seg=%h dp=%b run=%b ovf=%b", an, seg, dp, run, ovf);
    end
    rst_n = 1;
    @(posedge clk); #1;
    pulse_ss();
    pulse_slow(754);
    check_time(0, "reset_preload_12_34");
    #1 rst_n = 0;
    #1;
    n_chk++;
    if (an[0] !== 4'b1110 || seg[0] !== 7'b1000000 || run[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: an=%b seg=%b run=%b ovf=%b, expected 1110 1000000 0 0", an[0], seg[0], run[0], ovf[0]);
    end
    model_reset();
    clear = 0; start_stop = 0; slow_clk = 0; mid_clk = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    check_time(0, "reset_time_zero");
    n_chk++;
    if (run[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: running=%b expected 0", run[0]);
    end
  endtask

  task automatic test_count();
    pulse_clr();
    pulse_ss();
    pulse_slow(75);
    check_time(0, "count_75");
    n_chk++;
    if (run[0] !== 1'b1) begin n_fail++; $display("FAIL count_running: running=%b expected 1", run[0]); end
    pulse_ss();
    pulse_slow(10);
    check_time(0, "count_paused");
    n_chk++;
    if (run[0] !== 1'b0) begin n_fail++; $display("FAIL count_paused_running: running=%b expected 0", run[0]); end
    pulse_ss();
    pulse_slow(1);
    check_time(0, "count_resume");
  endtask

  task automatic test_prescale();
    pulse_clr();
    pulse_ss();
    pulse_slow(3);
    pulse_ss();
    pulse_ss();
    pulse_slow(1);
    check_time(1, "prescale_partial_resume");
    repeat (50) step(0, 0, 1, 0);
    idle_cyc();
    check_time(1, "prescale_level_hold");
    pulse_slow(3);
    check_time(1, "prescale_after_hold");
  endtask

  task automatic test_rollover();
    pulse_clr();
    pulse_ss();
    pulse_slow(3599);
    check_time(0, "rollover_59_59");
    pulse_slow(1);
    check_time(0, "rollover_00_00");
    n_chk++;
    if (ovf[0] !== m_ovf[0] || run[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rollover_flags: ovf=%b run=%b expected %b 1", ovf[0], run[0], m_ovf[0]);
    end
    pulse_clr();
    n_chk++;
    if (ovf[0] !== 1'b0 || run[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rollover_clear: ovf=%b run=%b expected 0 0", ovf[0], run[0]);
    end
  endtask

  task automatic test_simultaneous();
    pulse_clr();
    pulse_ss();
    pulse_slow(5);
    step(1, 1, 1, 0);
    idle_cyc();
    check_time(0, "simul_clear_wins");
    n_chk++;
    if (run[0] !== 1'b0) begin n_fail++; $display("FAIL simul_clear_idle: running=%b expected 0", run[0]); end
    pulse_ss();
    pulse_slow(2);
    step(0, 1, 1, 0);
    idle_cyc();
    check_time(0, "simul_pause_counts");
    n_chk++;
    if (run[0] !== 1'b0 || m_secs[0] != 3) begin
      n_fail++;
      $display("FAIL simul_paused: running=%b expected 0, model %0d s expected 3", run[0], m_secs[0]);
    end
  endtask

  task automatic test_scan();
    do_reset();
    pulse_ss();
    pulse_slow(267);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] ea;
      logic [6:0] es;
      pulse_mid();
      ea = ~(4'b0001 << m_idx);
      es = codes[digit_of(m_secs[0], m_idx)];
      n_chk++;
      if (an[0] !== ea || seg[0] !== es || dp[0] !== (m_idx != 2)) begin
        n_fail++;
        $display("FAIL scan_step%0d: an=%b seg=%b dp=%b expected %b %b %b", i, an[0], seg[0], dp[0], ea, es, m_idx != 2);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0) pulse_clr();
      else if (op <= 2) pulse_ss();
      else if (op == 3) begin
        step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        idle_cyc();
      end else pulse_slow($urandom_range(1, 20));
      n_chk++;
      if (run[0] !== (m_st[0] == 1) || run[1] !== (m_st[1] == 1) || ovf[0] !== m_ovf[0] || ovf[1] !== m_ovf[1]) begin
        n_fail++;
        $display("FAIL random_flags_it%0d: run=%b ovf=%b", it, run, ovf);
      end
      if (it % 8 == 7) begin
        check_time(0, "random_time_dut1");
        check_time(1, "random_time_dut4");
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_count();
    test_prescale();
    test_rollover();
    test_simultaneous();
    test_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
